dual_issue_dispatch_buffer: RTL and testbench
=============================================

Name: dual_issue_dispatch_buffer

Overview:
- Instruction buffer between Decode and the two issue pipelines (Branch pipeline, Memory pipeline) of the dual-issue core.
- Accepts up to 2 decoded instructions per cycle and steers them in program order to the pipeline matching their class.
- Splits pairs that cannot co-issue (structural or intra-pair register conflict) and honours issue stall and flush from the hazard logic.
- Acts as the consumer of that logic's stall/flush outputs.

Parameters:
- DEPTH, 8, FIFO entries (single instructions); power of 2, >=4
- XLEN, 32, PC/instruction width

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- dec_valid  in  2  per-slot valid; slot0 older than slot1; slot1 valid only with slot0 valid
- dec_pc  in  2*XLEN  per-slot PC
- dec_instr  in  2*XLEN  per-slot instruction word
- dec_class  in  2*2  per slot: 00 ALU, 01 branch/jump, 10 load, 11 store
- dec_rd / dec_rs1 / dec_rs2  in  2*5 each  register indices
- dec_rf_we  in  2  per-slot register-file write enable
- dec_ready  out  1  1 when free entries >= 2
- issue_stall  in  1  hold issue registers, no pop
- flush  in  1  discard all buffered and issued-register contents
- br_valid, br_pc, br_instr, br_class, br_rd, br_rs1, br_rs2, br_rf_we  out  1/XLEN/XLEN/2/5/5/5/1  Branch-pipeline issue register
- mem_valid, mem_pc, mem_instr, mem_class, mem_rd, mem_rs1, mem_rs2, mem_rf_we  out  same widths  Memory-pipeline issue register
- split_count  out  16  saturating count of split issues

Behaviour:
- Reset (rst_n=0 at posedge):
  - FIFO empty; all output valids 0; all output payloads 0.
  - split_count 0; dec_ready 1 on the cycle after reset.
- FIFO write:
  - Occurs when dec_ready=1 and dec_valid != 0.
  - Slot0 is written before slot1; dec_valid=01 writes 1 entry, 11 writes 2.
  - dec_valid=10 is illegal; ignore slot1.
- Writes while dec_ready=0 are dropped. Decode must hold its inputs.
- Latency: instruction written at edge N is eligible at edge N+1 and visible on outputs after edge N+1 (2 edges minimum).
- Issue evaluation runs each cycle when issue_stall=0. H0 = head, H1 = head+1 (only if count >= 2).
- Pair-issue conditions (all must hold):
  - Both present.
  - Not both in {load, store}.
  - Not both branch.
  - Not (H0.rf_we && H0.rd != 0 && (H1.rs1 == H0.rd || H1.rs2 == H0.rd)).
  - Not (H0.rf_we && H1.rf_we && H0.rd == H1.rd && H0.rd != 0).
- Steering for a pair:
  - Load/store goes to mem; branch goes to br.
  - ALU+ALU: H0 to br, H1 to mem.
  - ALU paired with X: ALU takes the pipe X does not use.
  - Pop 2.
- Single issue:
  - Applies when the pair conditions fail, or only H0 is present.
  - H0 goes to mem if load/store, else to br. Other pipe valid=0. Pop 1.
  - If H1 existed, split_count += 1, saturating at 0xFFFF.
- Empty FIFO: both valids 0 at the next edge.
- Younger instruction never issues before an older one. Issue reads the FIFO state from before this cycle's write; there is no bypass.
- issue_stall=1: both issue registers hold (valid and payload); no pop; writes continue while dec_ready=1.
- flush=1 (highest priority, overrides stall and write):
  - At the edge, FIFO count 0 and both valids 0.
  - Decode inputs in that cycle are dropped; split_count is unchanged.
- Simultaneous write of 2 and pop of 2: count unchanged; pointers wrap modulo DEPTH.
- dec_ready = (DEPTH - count) >= 2, computed from registered count (no same-cycle pop credit).
- Full FIFO (count = DEPTH or DEPTH-1): dec_ready=0; pop continues normally.
- Reset asserted mid-operation: identical to power-on reset at that edge; all in-flight entries are lost.

Test Plan:
- Reset, then write ALU(rd=5) + load(rs1=6) in one cycle -> two edges later br_valid=1 (ALU, rd=5), mem_valid=1 (load); split_count=0.
- Write load + store pair -> cycle 1: mem_valid=1 load, br_valid=0; next cycle: mem_valid=1 store; split_count=1.
- Write ALU(rd=7, we=1) + ALU(rs2=7) -> ALU1 issues alone on br; ALU2 issues next cycle on br; split_count=1. Repeat with rd=0 -> pair co-issues.
- Fill 8 entries with issue_stall=1 -> dec_ready falls to 0 at count=7; outputs hold unchanged; release stall -> drains in order, dec_ready returns 1.
- Assert flush with 5 entries buffered and both valids 1 plus a concurrent decode write -> next cycle valids 0, count 0, dec_ready 1, written pair discarded.
- Drive rst_n=0 for one cycle mid-drain -> all valids 0, split_count 0; a new pair issues correctly afterwards.

Source files
------------

// File: rtl/dual_issue_dispatch_buffer_if.sv
// Decode-to-dispatch and dispatch-to-issue bundle for the dual-issue buffer.
// master = decode/issue side, slave = dispatch buffer.
interface dual_issue_dispatch_buffer_if #(
    parameter int XLEN = 32
);
    logic [1:0]        dec_valid;
    logic [2*XLEN-1:0] dec_pc;
    logic [2*XLEN-1:0] dec_instr;
    logic [3:0]        dec_class;
    logic [9:0]        dec_rd;
    logic [9:0]        dec_rs1;
    logic [9:0]        dec_rs2;
    logic [1:0]        dec_rf_we;
    logic              dec_ready;

    logic              br_valid;
    logic [XLEN-1:0]   br_pc;
    logic [XLEN-1:0]   br_instr;
    logic [1:0]        br_class;
    logic [4:0]        br_rd;
    logic [4:0]        br_rs1;
    logic [4:0]        br_rs2;
    logic              br_rf_we;

    logic              mem_valid;
    logic [XLEN-1:0]   mem_pc;
    logic [XLEN-1:0]   mem_instr;
    logic [1:0]        mem_class;
    logic [4:0]        mem_rd;
    logic [4:0]        mem_rs1;
    logic [4:0]        mem_rs2;
    logic              mem_rf_we;

    modport master (
        output dec_valid, dec_pc, dec_instr, dec_class,
        output dec_rd, dec_rs1, dec_rs2, dec_rf_we,
        input  dec_ready,
        input  br_valid, br_pc, br_instr, br_class,
        input  br_rd, br_rs1, br_rs2, br_rf_we,
        input  mem_valid, mem_pc, mem_instr, mem_class,
        input  mem_rd, mem_rs1, mem_rs2, mem_rf_we
    );

    modport slave (
        input  dec_valid, dec_pc, dec_instr, dec_class,
        input  dec_rd, dec_rs1, dec_rs2, dec_rf_we,
        output dec_ready,
        output br_valid, br_pc, br_instr, br_class,
        output br_rd, br_rs1, br_rs2, br_rf_we,
        output mem_valid, mem_pc, mem_instr, mem_class,
        output mem_rd, mem_rs1, mem_rs2, mem_rf_we
    );
endinterface

// File: rtl/dual_issue_dispatch_buffer.sv
// In-order dispatch FIFO steering up to two instructions per cycle
// into the branch and memory issue registers.
module dual_issue_dispatch_buffer #(
    parameter int DEPTH = 8,
    parameter int XLEN  = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        issue_stall,
    input  logic        flush,
    output logic [15:0] split_count,
    dual_issue_dispatch_buffer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] C_ALU = 2'b00;
    localparam logic [1:0] C_BR  = 2'b01;

    typedef logic [AW-1:0] ptr_t;
    typedef logic [AW:0]   cnt_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic [1:0]      cls;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic            rf_we;
    } entry_t;

    entry_t fifo [DEPTH];
    ptr_t   head;
    ptr_t   tail;
    cnt_t   count;

    entry_t slot [2];
    logic   wr_en;
    logic   wr_two;
    logic [1:0] wr_n;

    entry_t h0;
    entry_t h1;
    logic   have0;
    logic   have1;
    logic   raw;
    logic   waw;
    logic   both_mem;
    logic   both_br;
    logic   pair_ok;

    entry_t br_n;
    entry_t mem_n;
    logic   br_vn;
    logic   mem_vn;
    logic [1:0] pop_n;
    logic   split;

    entry_t br_q;
    entry_t mem_q;
    logic   br_v;
    logic   mem_v;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            slot[i]       = '0;
            slot[i].pc    = bus.dec_pc[i*XLEN +: XLEN];
            slot[i].instr = bus.dec_instr[i*XLEN +: XLEN];
            slot[i].cls   = bus.dec_class[i*2 +: 2];
            slot[i].rd    = bus.dec_rd[i*5 +: 5];
            slot[i].rs1   = bus.dec_rs1[i*5 +: 5];
            slot[i].rs2   = bus.dec_rs2[i*5 +: 5];
            slot[i].rf_we = bus.dec_rf_we[i];
        end
    end

    // Readiness uses the registered count only; a same-cycle pop gives no credit.
    assign bus.dec_ready = (count <= cnt_t'(DEPTH - 2));

    assign wr_en  = bus.dec_ready && bus.dec_valid[0];
    assign wr_two = bus.dec_valid[1];
    assign wr_n   = wr_en ? (wr_two ? 2'd2 : 2'd1) : 2'd0;

    assign h0    = fifo[head];
    assign h1    = fifo[head + ptr_t'(1)];
    assign have0 = (count != '0);
    assign have1 = (count >= cnt_t'(2));

    assign raw = h0.rf_we && (h0.rd != 5'd0) &&
                 ((h1.rs1 == h0.rd) || (h1.rs2 == h0.rd));
    assign waw = h0.rf_we && h1.rf_we &&
                 (h0.rd == h1.rd) && (h0.rd != 5'd0);

    assign both_mem = h0.cls[1] && h1.cls[1];
    assign both_br  = (h0.cls == C_BR) && (h1.cls == C_BR);

    assign pair_ok = have1 && !both_mem && !both_br && !raw && !waw;

    always_comb begin
        br_n   = '0;
        mem_n  = '0;
        br_vn  = 1'b0;
        mem_vn = 1'b0;
        pop_n  = 2'd0;
        split  = 1'b0;
        if (pair_ok) begin
            pop_n  = 2'd2;
            br_vn  = 1'b1;
            mem_vn = 1'b1;
            // The non-ALU member picks its pipe; the ALU takes the other.
            priority case (1'b1)
                h0.cls[1]: begin
                    mem_n = h0;
                    br_n  = h1;
                end
                h1.cls[1]: begin
                    mem_n = h1;
                    br_n  = h0;
                end
                (h1.cls == C_BR): begin
                    br_n  = h1;
                    mem_n = h0;
                end
                default: begin
                    br_n  = h0;
                    mem_n = h1;
                end
            endcase
        end else if (have0) begin
            pop_n = 2'd1;
            split = have1;
            if (h0.cls[1]) begin
                mem_vn = 1'b1;
                mem_n  = h0;
            end else begin
                br_vn = 1'b1;
                br_n  = h0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && !flush && wr_en) begin
            fifo[tail] <= slot[0];
            if (wr_two) begin
                fifo[tail + ptr_t'(1)] <= slot[1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            br_v        <= 1'b0;
            mem_v       <= 1'b0;
            br_q        <= '0;
            mem_q       <= '0;
            split_count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            br_v  <= 1'b0;
            mem_v <= 1'b0;
            br_q  <= '0;
            mem_q <= '0;
        end else begin
            if (wr_en) begin
                tail <= tail + ptr_t'(wr_n);
            end
            if (!issue_stall) begin
                head  <= head + ptr_t'(pop_n);
                br_v  <= br_vn;
                mem_v <= mem_vn;
                br_q  <= br_n;
                mem_q <= mem_n;
                if (split && (split_count != 16'hFFFF)) begin
                    split_count <= split_count + 16'd1;
                end
            end
            count <= count + cnt_t'(wr_n)
                   - cnt_t'(issue_stall ? 2'd0 : pop_n);
        end
    end

    assign bus.br_valid  = br_v;
    assign bus.br_pc     = br_q.pc;
    assign bus.br_instr  = br_q.instr;
    assign bus.br_class  = br_q.cls;
    assign bus.br_rd     = br_q.rd;
    assign bus.br_rs1    = br_q.rs1;
    assign bus.br_rs2    = br_q.rs2;
    assign bus.br_rf_we  = br_q.rf_we;

    assign bus.mem_valid = mem_v;
    assign bus.mem_pc    = mem_q.pc;
    assign bus.mem_instr = mem_q.instr;
    assign bus.mem_class = mem_q.cls;
    assign bus.mem_rd    = mem_q.rd;
    assign bus.mem_rs1   = mem_q.rs1;
    assign bus.mem_rs2   = mem_q.rs2;
    assign bus.mem_rf_we = mem_q.rf_we;
endmodule

// File: tb/tb_dual_issue_dispatch_buffer.sv
// Directed bench for the dual-issue dispatch buffer.
// Expected values are hand-derived per vector.
module tb_dual_issue_dispatch_buffer;
    logic        clk;
    logic        rst_n;
    logic        issue_stall;
    logic        flush;
    logic [15:0] split_count;

    int n_tests;
    int n_fail;

    dual_issue_dispatch_buffer_if #(.XLEN(32)) bus ();

    dual_issue_dispatch_buffer #(
        .DEPTH (8),
        .XLEN  (32)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue_stall (issue_stall),
        .flush       (flush),
        .split_count (split_count),
        .bus         (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_slot(input int s, input logic [1:0] c,
                            input logic [4:0] rd, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic we,
                            input logic [31:0] pc);
        bus.dec_class[s*2 +: 2] = c;
        bus.dec_rd[s*5 +: 5]    = rd;
        bus.dec_rs1[s*5 +: 5]   = rs1;
        bus.dec_rs2[s*5 +: 5]   = rs2;
        bus.dec_rf_we[s]        = we;
        bus.dec_pc[s*32 +: 32]  = pc;
        bus.dec_instr[s*32 +: 32] = pc ^ 32'h5A00_0000;
    endtask

    // Plain ALU pair with no register dependences.
    task automatic alu_pair(input logic [31:0] pc);
        set_slot(0, 2'b00, 5'd0, 5'd1, 5'd2, 1'b0, pc);
        set_slot(1, 2'b00, 5'd0, 5'd3, 5'd4, 1'b0, pc + 32'd4);
        bus.dec_valid = 2'b11;
    endtask

    task automatic idle();
        bus.dec_valid = 2'b00;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n       = 1'b0;
        issue_stall = 1'b0;
        flush       = 1'b0;
        bus.dec_valid = '0;
        bus.dec_pc    = '0;
        bus.dec_instr = '0;
        bus.dec_class = '0;
        bus.dec_rd    = '0;
        bus.dec_rs1   = '0;
        bus.dec_rs2   = '0;
        bus.dec_rf_we = '0;

        step();
        step();
        check("rst_br_valid", 32'(bus.br_valid), 32'd0);
        check("rst_mem_valid", 32'(bus.mem_valid), 32'd0);
        check("rst_split", 32'(split_count), 32'd0);
        check("rst_br_pc", bus.br_pc, 32'd0);
        rst_n = 1'b1;
        step();
        check("rst_ready", 32'(bus.dec_ready), 32'd1);

        // ALU(rd=5) + load(rs1=6) co-issue.
        set_slot(0, 2'b00, 5'd5, 5'd1, 5'd2, 1'b1, 32'h100);
        set_slot(1, 2'b10, 5'd9, 5'd6, 5'd0, 1'b1, 32'h104);
        bus.dec_valid = 2'b11;
        step();
        idle();
        check("t1_lat_br", 32'(bus.br_valid), 32'd0);
        step();
        check("t1_br_valid", 32'(bus.br_valid), 32'd1);
        check("t1_br_rd", 32'(bus.br_rd), 32'd5);
        check("t1_br_pc", bus.br_pc, 32'h100);
        check("t1_br_instr", bus.br_instr, 32'h5A00_0100);
        check("t1_mem_valid", 32'(bus.mem_valid), 32'd1);
        check("t1_mem_class", 32'(bus.mem_class), 32'd2);
        check("t1_mem_pc", bus.mem_pc, 32'h104);
        check("t1_split", 32'(split_count), 32'd0);
        step();
        check("t1_empty_br", 32'(bus.br_valid), 32'd0);
        check("t1_empty_mem", 32'(bus.mem_valid), 32'd0);

        // Load + store must split.
        set_slot(0, 2'b10, 5'd8, 5'd1, 5'd0, 1'b1, 32'h200);
        set_slot(1, 2'b11, 5'd0, 5'd2, 5'd3, 1'b0, 32'h204);
        bus.dec_valid = 2'b11;
        step();
        idle();
        step();
        check("t2_c1_mem_valid", 32'(bus.mem_valid), 32'd1);
        check("t2_c1_mem_pc", bus.mem_pc, 32'h200);
        check("t2_c1_br_valid", 32'(bus.br_valid), 32'd0);
        check("t2_c1_split", 32'(split_count), 32'd1);
        step();
        check("t2_c2_mem_pc", bus.mem_pc, 32'h204);
        check("t2_c2_mem_class", 32'(bus.mem_class), 32'd3);
        check("t2_c2_split", 32'(split_count), 32'd1);
        step();

        // RAW between ALUs: split.
        set_slot(0, 2'b00, 5'd7, 5'd1, 5'd2, 1'b1, 32'h300);
        set_slot(1, 2'b00, 5'd9, 5'd3, 5'd7, 1'b1, 32'h304);
        bus.dec_valid = 2'b11;
        step();
        idle();
        step();
        check("t3_c1_br_pc", bus.br_pc, 32'h300);
        check("t3_c1_mem_valid", 32'(bus.mem_valid), 32'd0);
        check("t3_c1_split", 32'(split_count), 32'd2);
        step();
        check("t3_c2_br_valid", 32'(bus.br_valid), 32'd1);
        check("t3_c2_br_pc", bus.br_pc, 32'h304);
        check("t3_c2_mem_valid", 32'(bus.mem_valid), 32'd0);
        step();

        // Same with rd=0: co-issues.
        set_slot(0, 2'b00, 5'd0, 5'd1, 5'd2, 1'b1, 32'h310);
        set_slot(1, 2'b00, 5'd9, 5'd3, 5'd0, 1'b1, 32'h314);
        bus.dec_valid = 2'b11;
        step();
        idle();
        step();
        check("t3b_br_pc", bus.br_pc, 32'h310);
        check("t3b_mem_pc", bus.mem_pc, 32'h314);
        check("t3b_mem_valid", 32'(bus.mem_valid), 32'd1);
        check("t3b_split", 32'(split_count), 32'd2);
        step();

        // WAW on rd=3: split.
        set_slot(0, 2'b00, 5'd3, 5'd1, 5'd2, 1'b1, 32'h320);
        set_slot(1, 2'b00, 5'd3, 5'd4, 5'd5, 1'b1, 32'h324);
        bus.dec_valid = 2'b11;
        step();
        idle();
        step();
        check("waw_mem_valid", 32'(bus.mem_valid), 32'd0);
        check("waw_split", 32'(split_count), 32'd3);
        step();
        step();

        // ALU then branch: branch takes br, ALU takes mem.
        set_slot(0, 2'b00, 5'd0, 5'd1, 5'd2, 1'b0, 32'h390);
        set_slot(1, 2'b01, 5'd0, 5'd3, 5'd4, 1'b0, 32'h394);
        bus.dec_valid = 2'b11;
        step();
        idle();
        step();
        check("ab_br_pc", bus.br_pc, 32'h394);
        check("ab_mem_pc", bus.mem_pc, 32'h390);
        check("ab_mem_class", 32'(bus.mem_class), 32'd0);
        step();

        // Two branches: split.
        set_slot(0, 2'b01, 5'd0, 5'd1, 5'd2, 1'b0, 32'h3A0);
        set_slot(1, 2'b01, 5'd0, 5'd3, 5'd4, 1'b0, 32'h3A4);
        bus.dec_valid = 2'b11;
        step();
        idle();
        step();
        check("bb_br_pc", bus.br_pc, 32'h3A0);
        check("bb_split", 32'(split_count), 32'd4);
        step();
        step();

        // Fill under stall, then drain.
        alu_pair(32'h400);
        step();
        idle();
        step();
        issue_stall = 1'b1;
        alu_pair(32'h410);
        step();
        alu_pair(32'h418);
        step();
        alu_pair(32'h420);
        step();
        check("fill_ready_c6", 32'(bus.dec_ready), 32'd1);
        set_slot(0, 2'b00, 5'd0, 5'd1, 5'd2, 1'b0, 32'h428);
        bus.dec_valid = 2'b01;
        step();
        check("fill_ready_c7", 32'(bus.dec_ready), 32'd0);
        alu_pair(32'h500);
        step();
        idle();
        check("fill_ready_drop", 32'(bus.dec_ready), 32'd0);
        check("hold_br_pc", bus.br_pc, 32'h400);
        check("hold_mem_pc", bus.mem_pc, 32'h404);
        check("hold_br_valid", 32'(bus.br_valid), 32'd1);
        issue_stall = 1'b0;
        step();
        check("drain1_br", bus.br_pc, 32'h410);
        check("drain1_mem", bus.mem_pc, 32'h414);
        check("drain1_ready", 32'(bus.dec_ready), 32'd1);
        step();
        check("drain2_br", bus.br_pc, 32'h418);
        check("drain2_mem", bus.mem_pc, 32'h41C);
        step();
        check("drain3_br", bus.br_pc, 32'h420);
        check("drain3_mem", bus.mem_pc, 32'h424);
        step();
        check("drain4_br", bus.br_pc, 32'h428);
        check("drain4_mem_v", 32'(bus.mem_valid), 32'd0);
        step();
        check("drain_end_br_v", 32'(bus.br_valid), 32'd0);
        check("drain_split", 32'(split_count), 32'd4);

        // Flush with 5 buffered and both valids set.
        alu_pair(32'h600);
        step();
        idle();
        step();
        issue_stall = 1'b1;
        alu_pair(32'h610);
        step();
        alu_pair(32'h618);
        step();
        set_slot(0, 2'b00, 5'd0, 5'd1, 5'd2, 1'b0, 32'h620);
        bus.dec_valid = 2'b01;
        step();
        check("pre_flush_br_v", 32'(bus.br_valid), 32'd1);
        check("pre_flush_mem_v", 32'(bus.mem_valid), 32'd1);
        flush = 1'b1;
        alu_pair(32'h700);
        step();
        flush = 1'b0;
        idle();
        issue_stall = 1'b0;
        check("flush_br_v", 32'(bus.br_valid), 32'd0);
        check("flush_mem_v", 32'(bus.mem_valid), 32'd0);
        check("flush_ready", 32'(bus.dec_ready), 32'd1);
        check("flush_split", 32'(split_count), 32'd4);
        step();
        check("post_flush_br_v", 32'(bus.br_valid), 32'd0);
        check("post_flush_mem_v", 32'(bus.mem_valid), 32'd0);

        // Reset mid-drain.
        set_slot(0, 2'b10, 5'd8, 5'd1, 5'd0, 1'b1, 32'h800);
        set_slot(1, 2'b11, 5'd0, 5'd2, 5'd3, 1'b0, 32'h804);
        bus.dec_valid = 2'b11;
        step();
        idle();
        step();
        check("mid_mem_pc", bus.mem_pc, 32'h800);
        check("mid_split", 32'(split_count), 32'd5);
        rst_n = 1'b0;
        step();
        check("mid_rst_mem_v", 32'(bus.mem_valid), 32'd0);
        check("mid_rst_br_v", 32'(bus.br_valid), 32'd0);
        check("mid_rst_split", 32'(split_count), 32'd0);
        check("mid_rst_ready", 32'(bus.dec_ready), 32'd1);
        rst_n = 1'b1;
        step();
        check("post_rst_mem_v", 32'(bus.mem_valid), 32'd0);
        set_slot(0, 2'b00, 5'd4, 5'd1, 5'd2, 1'b1, 32'h900);
        set_slot(1, 2'b11, 5'd0, 5'd5, 5'd6, 1'b0, 32'h904);
        bus.dec_valid = 2'b11;
        step();
        idle();
        step();
        check("new_br_pc", bus.br_pc, 32'h900);
        check("new_mem_pc", bus.mem_pc, 32'h904);
        check("new_mem_class", 32'(bus.mem_class), 32'd3);
        check("new_split", 32'(split_count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
